proj_input_router: RTL and testbench

// - Input-side counterpart of the 208-to-16 project output mux: routes the shared 16-bit io_in
//   pad bus to one of NPROJ per-project input hold registers, selected by the same 4-bit sel.
// - Unselected projects see stable, held inputs.
// - Load strobe from pads is synchronized, edge-detected and qualified by a sel-settle window,
//   so a sel change never corrupts another project's inputs.

---
 rtl/proj_input_router.sv | 159 +++++++++++++++
 tb/tb_proj_input_router.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/proj_input_router.sv
// -----------------------------------------------------------------------------
// proj_input_router
// Routes the shared io_in pad bus to one of NPROJ per-project hold registers,
// selected by sel. It is the input-side counterpart of the project output mux.
// Unselected slots keep their held values.
//
// io_in and load arrive asynchronously, so both pass through a 2-flop
// synchronizer. A rising edge on the synchronized load requests a capture.
// The capture is accepted only when sel has been stable for SETTLE cycles.
//
// Ports:
//   clk        - single clock
//   rst        - asynchronous, active-low reset
//   io_in      - raw pad data, asynchronous to clk
//   load       - raw pad strobe; a rising edge requests a capture
//   sel        - target slot; values >= NPROJ alias to slot 0
//   clr        - synchronous clear of all hold registers and valid flags
//   proj_bus   - slot i is at bits [i*INPUTS +: INPUTS]
//   proj_valid - slot i has been written since the last reset or clr
//   done       - 1-cycle pulse: a capture was committed
//   dropped    - 1-cycle pulse: a load edge was rejected
//   busy       - high whenever the selector is not armed
// -----------------------------------------------------------------------------
module proj_input_router #(
  parameter int INPUTS = 16,
  parameter int NPROJ  = 13,
  parameter int SETTLE = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INPUTS-1:0]         io_in,
  input  logic                      load,
  input  logic [3:0]                sel,
  input  logic                      clr,
  output logic [NPROJ*INPUTS-1:0]   proj_bus,
  output logic [NPROJ-1:0]          proj_valid,
  output logic                      done,
  output logic                      dropped,
  output logic                      busy
);

  localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [0:0] {
    SETTLING = 1'b0,
    ARMED    = 1'b1
  } state_t;

  state_t            state_r;
  logic [CNTW-1:0]   cnt_r;
  logic [3:0]        sel_q_r;

  logic [INPUTS-1:0] io_s1_r;
  logic [INPUTS-1:0] io_s2_r;
  logic              load_s1_r;
  logic              load_s2_r;
  logic              load_s3_r;

  logic              ld_edge_s;
  logic              sel_chg_s;
  logic [3:0]        slot_s;
  logic              accept_s;
  logic              reject_s;

  // Edge detect, slot decode, and the accept/reject decision for a load edge.
  always_comb begin
    ld_edge_s = load_s2_r & ~load_s3_r;
    sel_chg_s = (sel != sel_q_r);
    if ({1'b0, sel_q_r} < 5'(NPROJ)) begin
      slot_s = sel_q_r;
    end else begin
      slot_s = 4'd0;
    end
    // A sel change or a clr in the same cycle wins over the capture.
    accept_s = ld_edge_s & (state_r == ARMED) & ~sel_chg_s & ~clr;
    reject_s = ld_edge_s & ~accept_s;
  end

  // Two-flop synchronizers for pad data and strobe, plus the edge-detect delay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io_s1_r   <= {INPUTS{1'b0}};
      io_s2_r   <= {INPUTS{1'b0}};
      load_s1_r <= 1'b0;
      load_s2_r <= 1'b0;
      load_s3_r <= 1'b0;
    end else begin
      io_s1_r   <= io_in;
      io_s2_r   <= io_s1_r;
      load_s1_r <= load;
      load_s2_r <= load_s1_r;
      load_s3_r <= load_s2_r;
    end
  end

  // Sel-settle FSM; busy is registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= SETTLING;
      cnt_r   <= CNTW'(SETTLE);
      sel_q_r <= 4'd0;
      busy    <= 1'b1;
    end else if (sel_chg_s) begin
      // Any sel movement restarts the settle window, whatever the state.
      state_r <= SETTLING;
      cnt_r   <= CNTW'(SETTLE);
      sel_q_r <= sel;
      busy    <= 1'b1;
    end else begin
      case (state_r)
        SETTLING: begin
          cnt_r <= cnt_r - CNTW'(1);
          if (cnt_r == CNTW'(1)) begin
            state_r <= ARMED;
            busy    <= 1'b0;
          end else begin
            busy    <= 1'b1;
          end
        end
        ARMED: begin
          busy <= 1'b0;
        end
        default: begin
          state_r <= SETTLING;
          cnt_r   <= CNTW'(SETTLE);
          busy    <= 1'b1;
        end
      endcase
    end
  end

  // Hold registers, valid flags, and the done/dropped status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      proj_bus   <= {(NPROJ*INPUTS){1'b0}};
      proj_valid <= {NPROJ{1'b0}};
      done       <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      done    <= accept_s;
      dropped <= reject_s;
      if (clr) begin
        proj_bus   <= {(NPROJ*INPUTS){1'b0}};
        proj_valid <= {NPROJ{1'b0}};
      end else if (accept_s) begin
        for (int i = 0; i < NPROJ; i++) begin
          if (slot_s == 4'(i)) begin
            proj_bus[i*INPUTS +: INPUTS] <= io_s2_r;
            proj_valid[i]                <= 1'b1;
          end
        end
      end else begin
        proj_bus   <= proj_bus;
        proj_valid <= proj_valid;
      end
    end
  end

endmodule

// File: tb/tb_proj_input_router.sv
module tb_proj_input_router;

  localparam int INPUTS = 16;
  localparam int NPROJ  = 13;
  localparam int SETTLE = 2;

  logic                    clk;
  logic                    rst;
  logic [INPUTS-1:0]       io_in;
  logic                    load;
  logic [3:0]              sel;
  logic                    clr;
  logic [NPROJ*INPUTS-1:0] proj_bus;
  logic [NPROJ-1:0]        proj_valid;
  logic                    done;
  logic                    dropped;
  logic                    busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [NPROJ*INPUTS-1:0] exp_bus;

  proj_input_router #(.INPUTS(INPUTS), .NPROJ(NPROJ), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .io_in      (io_in),
    .load       (load),
    .sel        (sel),
    .clr        (clr),
    .proj_bus   (proj_bus),
    .proj_valid (proj_valid),
    .done       (done),
    .dropped    (dropped),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load pulse sampled at exactly one edge; returns just after the commit edge.
  task automatic capture(input logic [15:0] d);
    io_in = d;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; io_in = 16'h0000; load = 1'b0; sel = 4'd0; clr = 1'b0;
    tick(); tick();
    total_cnt++;
    if (proj_bus !== '0) $display("FAIL reset_bus got=%h exp=0", proj_bus); else pass_cnt++;
    total_cnt++;
    if (proj_valid !== 13'h0000) $display("FAIL reset_valid got=%h exp=0", proj_valid); else pass_cnt++;
    total_cnt++;
    if ({done, dropped, busy} !== 3'b001) $display("FAIL reset_flags got=%b exp=001", {done, dropped, busy}); else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL settle_busy1 got=%b exp=1", busy); else pass_cnt++;
    tick();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL settle_armed got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_first_capture();
    tick();
    capture(16'hA5C3);
    total_cnt++;
    if (proj_bus[15:0] !== 16'hA5C3) $display("FAIL cap0_data got=%h exp=a5c3", proj_bus[15:0]); else pass_cnt++;
    total_cnt++;
    if (proj_valid !== 13'h0001) $display("FAIL cap0_valid got=%h exp=0001", proj_valid); else pass_cnt++;
    total_cnt++;
    if (done !== 1'b1) $display("FAIL cap0_done got=%b exp=1", done); else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b0) $display("FAIL cap0_done_pulse got=%b exp=0", done); else pass_cnt++;
  endtask

  task automatic test_two_slots();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total_cnt++;
    if (proj_valid !== 13'h0000 || proj_bus !== '0) $display("FAIL clr_all got=%h exp=0", proj_valid); else pass_cnt++;
    sel = 4'd5;
    tick(); tick(); tick();
    capture(16'h1234);
    total_cnt++;
    if (done !== 1'b1) $display("FAIL cap5_done got=%b exp=1", done); else pass_cnt++;
    sel = 4'd7;
    tick(); tick(); tick();
    capture(16'hBEEF);
    exp_bus = '0;
    exp_bus[5*INPUTS +: INPUTS] = 16'h1234;
    exp_bus[7*INPUTS +: INPUTS] = 16'hBEEF;
    total_cnt++;
    if (proj_bus !== exp_bus) $display("FAIL two_slots_bus got=%h exp=%h", proj_bus, exp_bus); else pass_cnt++;
    total_cnt++;
    if (proj_valid !== 13'h00A0) $display("FAIL two_slots_valid got=%h exp=00a0", proj_valid); else pass_cnt++;
  endtask

  task automatic test_settle_drop();
    sel = 4'd3;
    tick(); tick(); tick();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL sel3_armed got=%b exp=0", busy); else pass_cnt++;
    // sel moves to 4 and the strobe lands while the window is still open.
    sel = 4'd4; io_in = 16'hDEAD; load = 1'b1;
    tick();
    load = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL drop_busy_a got=%b exp=1", busy); else pass_cnt++;
    tick();
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL drop_busy_b got=%b exp=1", busy); else pass_cnt++;
    tick();
    total_cnt++;
    if ({done, dropped} !== 2'b01) $display("FAIL drop_pulse got=%b exp=01", {done, dropped}); else pass_cnt++;
    total_cnt++;
    if (proj_valid !== 13'h00A0 || proj_bus !== exp_bus) $display("FAIL drop_nowrite got=%h exp=00a0", proj_valid); else pass_cnt++;
    tick();
    total_cnt++;
    if (dropped !== 1'b0) $display("FAIL drop_pulse_end got=%b exp=0", dropped); else pass_cnt++;
  endtask

  task automatic test_alias();
    sel = 4'hE;
    tick(); tick(); tick();
    capture(16'h0F0F);
    total_cnt++;
    if (proj_bus[15:0] !== 16'h0F0F) $display("FAIL alias_data got=%h exp=0f0f", proj_bus[15:0]); else pass_cnt++;
    total_cnt++;
    if (proj_valid !== 13'h00A1) $display("FAIL alias_valid got=%h exp=00a1", proj_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n_done;
    int n_drop;
    n_done = 0;
    n_drop = 0;
    io_in = 16'h7777;
    load  = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (i == 19) load = 1'b0;
      n_done += int'(done);
      n_drop += int'(dropped);
    end
    total_cnt++;
    if (n_done != 1 || n_drop != 0) $display("FAIL held_load got=%0d/%0d exp=1/0", n_done, n_drop); else pass_cnt++;
    total_cnt++;
    if (proj_bus[15:0] !== 16'h7777) $display("FAIL held_data got=%h exp=7777", proj_bus[15:0]); else pass_cnt++;
    // clr coincides with the synchronized edge.
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total_cnt++;
    if ({done, dropped} !== 2'b01) $display("FAIL clr_edge_flags got=%b exp=01", {done, dropped}); else pass_cnt++;
    total_cnt++;
    if (proj_bus !== '0 || proj_valid !== 13'h0000) $display("FAIL clr_edge_clear got=%h exp=0", proj_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid_capture();
    int n_done;
    capture(16'h5A5A);
    total_cnt++;
    if (proj_bus[15:0] !== 16'h5A5A) $display("FAIL pre_rst_data got=%h exp=5a5a", proj_bus[15:0]); else pass_cnt++;
    io_in = 16'h1111;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    total_cnt++;
    if (proj_bus !== '0 || proj_valid !== 13'h0000) $display("FAIL midrst_clear got=%h exp=0", proj_valid); else pass_cnt++;
    total_cnt++;
    if ({done, dropped, busy} !== 3'b001) $display("FAIL midrst_flags got=%b exp=001", {done, dropped, busy}); else pass_cnt++;
    tick();
    rst = 1'b1;
    n_done = 0;
    tick();
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL postrst_busy got=%b exp=1", busy); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      n_done += int'(done);
      tick();
    end
    total_cnt++;
    if (n_done != 0 || proj_valid !== 13'h0000) $display("FAIL postrst_nodone got=%0d exp=0", n_done); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_capture();
    test_two_slots();
    test_settle_drop();
    test_alias();
    test_back_to_back();
    test_reset_mid_capture();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
